// File: rtl/fpadd_sched_pkg.sv
// Shared types for the fp add/sub scheduler.
// Holds operand width, fp32 type, FSM states, sign flip helper.
package fpadd_sched_pkg;

  localparam int FP_W = 32;

  typedef logic [FP_W-1:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_t;

  function automatic fp32_t flip_sign(fp32_t v);
    return {~v[FP_W-1], v[FP_W-2:0]};
  endfunction

endpackage

// File: rtl/fpadd_sched_arb.sv
// Combinational round-robin arbiter.
// req: requests, ptr: highest-priority index, grant: one-hot winner.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic found;

  // Scan distances 0..NREQ-1 from ptr; the first
  // requester hit at the smallest distance wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] &&
            ((int'(ptr) + k) % NREQ) == i) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fpadd_sched.sv
// Shares one fp32 add/sub datapath among NREQ requesters.
// Ports: req_* in, rsp_* out, dp_* to/from adder, busy, op_count.
module fpadd_sched
  import fpadd_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADD_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FP_W-1:0] req_op1,
  input  logic [NREQ*FP_W-1:0] req_op2,
  input  logic [NREQ-1:0]      req_sub,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output fp32_t                rsp_result,
  output logic                 rsp_overflow,
  output fp32_t                dp_op1,
  output fp32_t                dp_op2,
  input  fp32_t                dp_result,
  input  logic                 dp_overflow,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  localparam int PTR_W =
    (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0] LAT = 3'(ADD_LAT);

  sched_state_t     state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] nxt_ptr;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  owner;
  logic [2:0]       cnt;
  logic             take;
  logic             done;
  logic             sel_sub;
  fp32_t            sel_op1;
  fp32_t            sel_op2;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign take      = |(req_valid & req_ready);
  // owner is one-hot, so foreign rsp_ready bits drop out
  assign done      = |(rsp_ready & owner);
  assign busy      = (state != IDLE);

  always_comb begin
    gidx    = '0;
    sel_op1 = '0;
    sel_op2 = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gidx    = PTR_W'(i);
        sel_op1 = req_op1[i*FP_W +: FP_W];
        sel_op2 = req_op2[i*FP_W +: FP_W];
        sel_sub = req_sub[i];
      end
    end
  end

  assign nxt_ptr = (int'(gidx) == NREQ - 1) ?
                   '0 : gidx + PTR_W'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      cnt          <= '0;
      dp_op1       <= '0;
      dp_op2       <= '0;
      rsp_valid    <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      op_count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            dp_op1 <= sel_op1;
            dp_op2 <= sel_sub ? flip_sign(sel_op2)
                              : sel_op2;
            owner  <= grant;
            rr_ptr <= nxt_ptr;
            cnt    <= LAT;
            state  <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            rsp_result   <= dp_result;
            rsp_overflow <= dp_overflow;
            rsp_valid    <= owner;
            state        <= RESP;
          end
        end
        RESP: begin
          if (done) begin
            rsp_valid <= '0;
            op_count  <= op_count + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpadd_sched.sv
// Self-checking bench for fpadd_sched with a
// real-arithmetic stand-in adder and a transaction model.
module tb_fpadd_sched;

  localparam int N   = 3;
  localparam int LAT = 3;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_op1;
  logic [N*32-1:0] req_op2;
  logic [N-1:0]  req_sub;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [31:0]   rsp_result;
  logic          rsp_overflow;
  logic [31:0]   dp_op1;
  logic [31:0]   dp_op2;
  logic [31:0]   dp_result;
  logic          dp_overflow;
  logic          busy;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  fpadd_sched #(
    .NREQ    (N),
    .ADD_LAT (LAT),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_sub      (req_sub),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .dp_op1       (dp_op1),
    .dp_op2       (dp_op2),
    .dp_result    (dp_result),
    .dp_overflow  (dp_overflow),
    .busy         (busy),
    .op_count     (op_count)
  );

  function automatic real to_real(input logic [31:0] a);
    logic [10:0] e;
    if (a[30:23] == 8'd0) return 0.0;
    e = 11'(a[30:23]) + 11'd896;
    return $bitstoreal({a[31], e, a[22:0], 29'b0});
  endfunction

  // Stand-in datapath: {overflow, result}, truncating.
  function automatic logic [32:0] fp_add(
    input logic [31:0] a, input logic [31:0] b);
    real s;
    logic [63:0] d;
    int e;
    logic [31:0] r;
    logic o;
    s = to_real(a) + to_real(b);
    d = $realtobits(s);
    e = int'(d[62:52]) - 1023 + 127;
    o = 1'b0;
    if (d[62:0] == 63'd0 || e <= 0) r = {d[63], 31'b0};
    else if (e >= 255) begin
      r = {d[63], 8'hFF, 23'b0};
      o = 1'b1;
    end else r = {d[63], e[7:0], d[51:29]};
    return {o, r};
  endfunction

  assign {dp_overflow, dp_result} = fp_add(dp_op1, dp_op2);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  logic        m_busy;
  int          m_owner;
  int          m_ptr;
  int          m_wait;
  int          m_cnt;
  logic [31:0] m_op1, m_op2, m_res, m_shown;
  logic        m_ovf, m_shown_ovf;
  int          mg;
  int          mj;
  logic [N-1:0] m_er;
  logic [N-1:0] m_ev;

  always @(negedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0;
      m_wait = 0; m_cnt = 0;
      m_op1 = '0; m_op2 = '0; m_res = '0;
      m_shown = '0; m_ovf = 1'b0; m_shown_ovf = 1'b0;
    end else begin
      mg = -1;
      if (!m_busy)
        for (int k = 0; k < N; k++) begin
          mj = (m_ptr + k) % N;
          if (mg < 0 && req_valid[mj]) mg = mj;
        end
      m_er = '0;
      if (mg >= 0) m_er[mg] = 1'b1;
      m_ev = '0;
      if (m_busy && m_wait == 0) m_ev[m_owner] = 1'b1;
      chk("m_req_ready", 64'(req_ready), 64'(m_er));
      chk("m_ready_1hot", 64'($countones(req_ready) <= 1), 64'd1);
      chk("m_rsp_valid", 64'(rsp_valid), 64'(m_ev));
      chk("m_busy", 64'(busy), 64'(m_busy));
      chk("m_result", 64'(rsp_result), 64'(m_shown));
      chk("m_ovf", 64'(rsp_overflow), 64'(m_shown_ovf));
      chk("m_dp_op1", 64'(dp_op1), 64'(m_op1));
      chk("m_dp_op2", 64'(dp_op2), 64'(m_op2));
      chk("m_op_count", 64'(op_count), 64'(m_cnt % (1 << CW)));
      if (mg >= 0) begin
        m_op1 = req_op1[mg*32 +: 32];
        m_op2 = req_op2[mg*32 +: 32];
        if (req_sub[mg]) m_op2[31] = ~m_op2[31];
        {m_ovf, m_res} = fp_add(m_op1, m_op2);
        m_owner = mg;
        m_ptr   = (mg + 1) % N;
        m_wait  = LAT;
        m_busy  = 1'b1;
      end else if (m_busy && m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_shown     = m_res;
          m_shown_ovf = m_ovf;
        end
      end else if (m_busy && rsp_ready[m_owner]) begin
        m_cnt++;
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [N-1:0] acc;

  task automatic tick();
    #1 acc = req_valid & req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
    req_op1[i*32 +: 32] = a;
    req_op2[i*32 +: 32] = b;
    req_sub[i] = s;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = ($urandom_range(0, 7) == 0) ?
        8'(254 - $urandom_range(0, 1)) :
        8'($urandom_range(110, 140));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '0;
    n_rst = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  int acc_ord[$];
  int acc_cyc[$];
  logic [31:0] held;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    req_valid = '0; rsp_ready = '0;
    req_op1 = '0; req_op2 = '0; req_sub = '0;
    acc = '0;
    #12;
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_result", 64'(rsp_result), 0);
    chk("rst_dp_op2", 64'(dp_op2), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_op_count", 64'(op_count), 0);
    @(posedge clk);
    #1 n_rst = 1'b1;

    // single add on requester 0
    set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    req_valid = 3'b001;
    tick();
    chk("add_acc", 64'(acc), 64'h1);
    req_valid = '0;
    chk("add_dp_op1", 64'(dp_op1), 64'h3F800000);
    chk("add_dp_op2", 64'(dp_op2), 64'h40000000);
    for (int k = 1; k < LAT; k++) begin
      tick();
      chk("add_early_valid", 64'(rsp_valid), 0);
    end
    tick();
    chk("add_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("add_result", 64'(rsp_result), 64'h40400000);
    rsp_ready = 3'b001;
    tick();
    chk("add_op_count", 64'(op_count), 1);
    chk("add_idle", 64'(busy), 0);

    // subtract on requester 1
    set_req(1, 32'h40400000, 32'h3F800000, 1'b1);
    req_valid = 3'b010;
    rsp_ready = '1;
    tick();
    chk("sub_acc", 64'(acc), 64'h2);
    req_valid = '0;
    chk("sub_dp_op2", 64'(dp_op2), 64'hBF800000);
    repeat (LAT) tick();
    chk("sub_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("sub_result", 64'(rsp_result), 64'h40000000);
    tick();

    // backpressure on requester 2
    set_req(2, 32'h40A00000, 32'h41200000, 1'b0);
    set_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
    req_valid = 3'b100;
    rsp_ready = '0;
    tick();
    chk("bp_acc", 64'(acc), 64'h4);
    req_valid = 3'b001;
    rsp_ready = 3'b011;
    repeat (LAT) tick();
    held = rsp_result;
    chk("bp_result", 64'(held), 64'h41700000);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 64'(rsp_valid), 64'h4);
      chk("bp_stable", 64'(rsp_result), 64'(held));
      chk("bp_ready", 64'(req_ready), 0);
      chk("bp_busy", 64'(busy), 1);
    end
    rsp_ready = 3'b100;
    tick();
    chk("bp_release_acc", 64'(acc), 0);
    chk("bp_release_busy", 64'(busy), 0);
    rsp_ready = '1;
    tick();
    chk("bp_next_acc", 64'(acc), 64'h1);
    req_valid = '0;
    repeat (LAT + 2) tick();

    // contention between requesters 0 and 1
    do_reset();
    set_req(0, rand_fp(), rand_fp(), 1'b0);
    set_req(1, rand_fp(), rand_fp(), 1'b1);
    req_valid = 3'b011;
    rsp_ready = '1;
    acc_ord.delete();
    acc_cyc.delete();
    for (int c = 0; c < 40 && acc_ord.size() < 4; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          acc_ord.push_back(i);
          acc_cyc.push_back(c);
        end
    end
    chk("cont_count", 64'(acc_ord.size()), 4);
    if (acc_ord.size() == 4) begin
      for (int k = 0; k < 4; k++)
        chk("cont_order", 64'(acc_ord[k]), 64'(k % 2));
      for (int k = 1; k < 4; k++)
        chk("cont_interval", 64'(acc_cyc[k] - acc_cyc[k-1]),
            64'(LAT + 2));
    end
    req_valid = '0;
    repeat (LAT + 2) tick();

    // reset during EXEC
    do_reset();
    set_req(1, rand_fp(), rand_fp(), 1'b0);
    req_valid = 3'b010;
    tick();
    chk("mid_acc", 64'(acc), 64'h2);
    tick();
    tick();
    #2 req_valid = '0;
    n_rst = 1'b0;
    #1;
    chk("mid_ready", 64'(req_ready), 0);
    chk("mid_valid", 64'(rsp_valid), 0);
    chk("mid_dp_op1", 64'(dp_op1), 0);
    chk("mid_dp_op2", 64'(dp_op2), 0);
    chk("mid_busy", 64'(busy), 0);
    chk("mid_result", 64'(rsp_result), 0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    rsp_ready = '1;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      chk("mid_no_rsp", 64'(rsp_valid), 0);
    end
    set_req(0, rand_fp(), rand_fp(), 1'b0);
    req_valid = 3'b011;
    tick();
    chk("mid_ptr0", 64'(acc), 64'h1);
    req_valid = '0;
    repeat (LAT + 2) tick();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, rand_fp(), rand_fp(), 1'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = N'($urandom);
      tick();
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (LAT + 3) tick();

    // counter wrap after 17 completions
    do_reset();
    set_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
    req_valid = 3'b001;
    rsp_ready = '1;
    repeat (17 * (LAT + 2)) tick();
    req_valid = '0;
    tick();
    chk("wrap_op_count", 64'(op_count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
